// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared pipeline definitions (state encodings, NOP, forwarding select codes)
package hazard_control_unit_pkg;
    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;
    localparam logic [31:0] NOP = 32'h00000013;
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_t;
endpackage

// File: rtl/hazard_control_unit_mem_wait_timer.sv
// mem_wait_timer: 8-bit saturating wait-cycle counter; hit while the count equals MEM_TIMEOUT
module mem_wait_timer
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    logic [7:0] cnt;
    assign hit = cnt == 8'(MEM_TIMEOUT);
    // clr together with inc restarts the count at 1 for the first wait cycle
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else
            cnt <= clr ? {7'd0, inc} : (inc && !hit) ? cnt + 8'd1 : cnt;
    end
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use / branch / memory-wait stall and flush generator.
// Define HAZARD_PERF_CNT_EN to build the stall_cnt / flush_cnt performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_RS1,
    input  logic [4:0]  IF_ID_RS2,
    input  logic        IF_ID_UseRS1,
    input  logic        IF_ID_UseRS2,
    input  logic [4:0]  ID_EX_RD,
    input  logic        ID_EX_MemRead,
    input  logic        EX_BranchTaken,
    input  logic        MEM_Req,
    input  logic        MEM_Ready,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        Pipe_Freeze,
    output logic        MEM_WB_Bubble,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    state_t     state;
    logic [2:0] lcnt;
    logic       err_q, hit, memwait, hazard, in_ld, stall_ld, flush;
    // A release from S_MEM_WAIT behaves exactly like S_RUN, so only S_LOAD_STALL needs decoding
    always_comb begin
        memwait       = MEM_Req && !MEM_Ready;
        hazard        = ID_EX_MemRead && ID_EX_RD != 5'd0 &&
                        ((IF_ID_UseRS1 && ID_EX_RD == IF_ID_RS1) || (IF_ID_UseRS2 && ID_EX_RD == IF_ID_RS2));
        in_ld         = state == S_LOAD_STALL;
        flush         = !memwait && !in_ld && EX_BranchTaken;
        stall_ld      = !memwait && (in_ld || (!EX_BranchTaken && hazard));
        PC_Write      = !rst && !memwait && !stall_ld;
        IF_ID_Write   = PC_Write;
        IF_ID_Flush   = rst || flush;
        ID_EX_Bubble  = rst || flush || stall_ld;
        Pipe_Freeze   = !rst && memwait;
        MEM_WB_Bubble = rst || memwait;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            lcnt  <= 3'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_q || hit;
            lcnt  <= in_ld ? lcnt + 3'd1 : 3'd1;
            if (memwait)
                state <= S_MEM_WAIT;
            else if (in_ld)
                state <= (lcnt == 3'(LOAD_USE_CYCLES - 1)) ? S_RUN : S_LOAD_STALL;
            else
                state <= (stall_ld && LOAD_USE_CYCLES > 1) ? S_LOAD_STALL : S_RUN;
        end
    end
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (!memwait || state != S_MEM_WAIT),
        .inc (memwait),
        .hit (hit)
    );
    assign mem_err = err_q || hit;
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, !PC_Write};
            flush_cnt <= flush_cnt + {31'd0, flush};
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: two configurations (default, and LOAD_USE_CYCLES=3/MEM_TIMEOUT=4) against a cycle model
module tb_hazard_control_unit;
    logic       clk = 1'b0;
    logic       rst, br, req, rdy, mr, u1, u2;
    logic [4:0] rd, rs1, rs2;
    wire  [5:0] ctl_a, ctl_b;
    wire        err_a, err_b;
    wire [31:0] sc_a, sc_b, fc_a, fc_b;
    int          n_assert = 0, n_fail = 0;
    int          rem [2], wt [2];
    bit          err [2];
    int unsigned stalls [2], flushes [2];
    int          lc [2] = '{1, 3};
    int          tm [2] = '{255, 4};

    always #5 clk = ~clk;

    hazard_control_unit u_a (
        .clk(clk), .rst(rst), .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_UseRS1(u1), .IF_ID_UseRS2(u2),
        .ID_EX_RD(rd), .ID_EX_MemRead(mr), .EX_BranchTaken(br), .MEM_Req(req), .MEM_Ready(rdy),
        .PC_Write(ctl_a[5]), .IF_ID_Write(ctl_a[4]), .IF_ID_Flush(ctl_a[3]), .ID_EX_Bubble(ctl_a[2]),
        .Pipe_Freeze(ctl_a[1]), .MEM_WB_Bubble(ctl_a[0]), .mem_err(err_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
    );
    hazard_control_unit #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(4)) u_b (
        .clk(clk), .rst(rst), .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_UseRS1(u1), .IF_ID_UseRS2(u2),
        .ID_EX_RD(rd), .ID_EX_MemRead(mr), .EX_BranchTaken(br), .MEM_Req(req), .MEM_Ready(rdy),
        .PC_Write(ctl_b[5]), .IF_ID_Write(ctl_b[4]), .IF_ID_Flush(ctl_b[3]), .ID_EX_Bubble(ctl_b[2]),
        .Pipe_Freeze(ctl_b[1]), .MEM_WB_Bubble(ctl_b[0]), .mem_err(err_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational controls, advance model, check registered state
    task automatic step(input bit r, input bit b, input bit q, input bit y, input bit m,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input bit e1, input bit e2);
        logic [5:0] exp;
        bit mw, hz;
        @(negedge clk);
        rst = r; br = b; req = q; rdy = y; mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = e1; u2 = e2;
        #1;
        mw = q && !y;
        hz = m && d != 5'd0 && ((e1 && d == s1) || (e2 && d == s2));
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                exp = 6'b001101;
                rem[i] = 0; wt[i] = 0; err[i] = 0; stalls[i] = 0; flushes[i] = 0;
            end else if (mw) begin
                exp = 6'b000011;
                wt[i] = (wt[i] < tm[i]) ? wt[i] + 1 : tm[i];
                if (wt[i] == tm[i]) err[i] = 1;
                rem[i] = 0;
                stalls[i]++;
            end else begin
                wt[i] = 0;
                if (rem[i] > 0) begin
                    exp = 6'b000100; rem[i]--; stalls[i]++;
                end else if (b) begin
                    exp = 6'b111100; flushes[i]++;
                end else if (hz) begin
                    exp = 6'b000100; rem[i] = lc[i] - 1; stalls[i]++;
                end else
                    exp = 6'b110000;
            end
            chk($sformatf("ctl[%0d]", i), {26'd0, i == 0 ? ctl_a : ctl_b}, {26'd0, exp});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mem_err[%0d]", i), {31'd0, i == 0 ? err_a : err_b}, {31'd0, err[i]});
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("stall_cnt[%0d]", i), i == 0 ? sc_a : sc_b, stalls[i]);
            chk($sformatf("flush_cnt[%0d]", i), i == 0 ? fc_a : fc_b, flushes[i]);
`else
            chk($sformatf("stall_cnt[%0d]", i), i == 0 ? sc_a : sc_b, 32'd0);
            chk($sformatf("flush_cnt[%0d]", i), i == 0 ? fc_a : fc_b, 32'd0);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int burst = 0;
        bit q, y;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 5, 5, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 5, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1, 7, 0, 7, 0, 1);
        step(0, 0, 0, 0, 0, 7, 0, 7, 0, 1);
        idle(3);
        step(0, 1, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 3, 3, 0, 1, 0);
        step(0, 1, 1, 1, 1, 3, 3, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 3, 0, 3, 0, 1);
        idle(3);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 9, 9, 9, 1, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        for (int k = 0; k < 600; k++) begin
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 8);
            if (burst > 0) begin
                q = 1; y = 0; burst--;
            end else begin
                q = $urandom_range(0, 2) == 0; y = $urandom_range(0, 1) == 1;
            end
            step($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, q, y, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
